placar_registro_times: RTL and testbench
========================================

// Module: placar_registro_times
// PURPOSE
//  Score-holding stage for the two-team basketball scoreboard. Consumes the 2-bit
//  point code from the button encoder (1/2/3 points), the add/subtract switch and
//  the team-select switch. Applies each button press exactly once to the selected
//  team's 7-bit score, clamped to the displayable range. Raises a timed buzzer/LED
//  alarm when an operation would leave that range. Feeds the 7-segment display stage.
// PARAMETERS
//  LARGURA        7           score register width (bits)
//  MAX_PONTOS     99          highest legal score (display limit)
//  ALARME_CICLOS  50_000_000  alarm duration in clk cycles (1 s @ 50 MHz); benches use 8
// PORTS
//  clk              in   1        system clock, rising edge
//  reset            in   1        asynchronous, active-high reset
//  pontos           in   2        point code from encoder: 0 none, 1/2/3 points; clean, clk-synchronous
//  chave_neg_pos    in   1        0 = add, 1 = subtract
//  mudar_time       in   1        0 = team A, 1 = team B
//  zerar            in   1        synchronous clear of both scores
//  placar_a         out  LARGURA  team A score
//  placar_b         out  LARGURA  team B score
//  placar_sel       out  LARGURA  score of team currently chosen by mudar_time (combinational mux)
//  alarme           out  1        buzzer/LED drive, high for ALARME_CICLOS cycles after a rejected op
//  ocupado          out  1        high in APLICA and ESPERA states
// BEHAVIOUR
//  Reset (async, active-high): placar_a = placar_b = 0, alarme = 0, alarm counter = 0, state OCIOSO.
//  FSM: OCIOSO -> APLICA -> ESPERA -> OCIOSO.
//   OCIOSO: at an edge with pontos != 0, latch valor = pontos, sinal = chave_neg_pos,
//           time = mudar_time; go to APLICA. pontos == 0 is never an event.
//   APLICA: one cycle. Compute r = score[time] +/- valor at LARGURA+1 bits.
//           Add: r <= MAX_PONTOS -> write r; else score unchanged, start alarm.
//           Subtract: score >= valor -> write score - valor; else unchanged, start alarm.
//           Always go to ESPERA.
//   ESPERA: hold until an edge samples pontos == 0, then go to OCIOSO.
//           Gives one update per press regardless of hold length.
//  Latency: pontos sampled nonzero at edge k -> score updated at edge k+1, visible after it.
//  Latched time and sign are used. Switch changes after edge k do not affect the pending op.
//  Alarm:
//   - A rejected op loads the counter with ALARME_CICLOS and sets alarme at edge k+1.
//   - The counter decrements each cycle. alarme clears on the edge where it reaches 0.
//   - A new reject while the alarm is active reloads the counter (retrigger).
//   - An accepted op does not affect the alarm.
//  zerar: priority over all FSM activity. At the sampling edge it sets both scores to 0,
//   clears alarme and the counter, and forces ESPERA if pontos != 0, else OCIOSO.
//  Boundaries:
//   - Adding to exactly MAX_PONTOS and subtracting to exactly 0 are legal (no alarm).
//   - Scores never wrap.
//   - pontos changing 1->3 without returning to 0 is not a new event.
//   - Reset mid-APLICA discards the pending op.
// TESTING
//  1 Reset; pontos=2 for 3 cycles, add, team A -> placar_a=2 one edge later, exactly once; placar_b=0.
//  2 mudar_time=1; press 3 twice, then 1 -> placar_b=7, placar_a unchanged, placar_sel=7.
//  3 A=98: add 1 -> 99, no alarm. Add 1 again -> A stays 99, alarme high exactly 8 cycles (ALARME_CICLOS=8).
//  4 A=1, subtract 2 -> A stays 1, alarm. Subtract 1 -> A=0, no alarm. Reject at cycle 3 of alarm -> alarm extends 8 more cycles.
//  5 Press latched for team A, flip mudar_time next cycle -> update lands in A.
//    Assert zerar mid-alarm -> scores 0, alarme 0 next edge.
//  6 Assert reset in APLICA -> all outputs 0 immediately, no update.
//    Hold pontos=1 across reset release -> no update until pontos returns to 0 and is pressed again.

Source files
------------

// File: rtl/placar_registro_times.sv
// Score registers for the two-team basketball scoreboard. Each button press updates the
// selected team's score exactly once, keeps it in 0..MAX_PONTOS and raises a timed alarm on a reject.
module placar_registro_times #(
    parameter int LARGURA       = 7,
    parameter int MAX_PONTOS    = 99,
    parameter int ALARME_CICLOS = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         pontos,
    input  logic               chave_neg_pos,
    input  logic               mudar_time,
    input  logic               zerar,
    output logic [LARGURA-1:0] placar_a,
    output logic [LARGURA-1:0] placar_b,
    output logic [LARGURA-1:0] placar_sel,
    output logic               alarme,
    output logic               ocupado
);
    localparam int CW = $clog2(ALARME_CICLOS + 1);
    localparam logic [CW-1:0] CARGA = CW'(ALARME_CICLOS);
    localparam logic [LARGURA:0] LIMITE = (LARGURA + 1)'(MAX_PONTOS);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        APLICA = 2'd1,
        ESPERA = 2'd2
    } estado_t;

    estado_t            estado;
    estado_t            proximo;
    logic [1:0]         valor_q;
    logic               sinal_q;
    logic               time_q;
    logic               armado;
    logic [CW-1:0]      contador;
    logic [LARGURA-1:0] atual;
    logic [LARGURA:0]   soma;
    logic [LARGURA-1:0] novo;
    logic               captura;
    logic               escreve;
    logic               rejeita;

    assign atual      = time_q ? placar_b : placar_a;
    assign soma       = {1'b0, atual} + {{(LARGURA - 1){1'b0}}, valor_q};
    assign placar_sel = mudar_time ? placar_b : placar_a;
    assign alarme     = (contador != '0);
    assign ocupado    = (estado == APLICA) || (estado == ESPERA);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= proximo;
    end

    // Next state and the single-cycle update decision; zerar overrides everything.
    always_comb begin
        proximo = estado;
        captura = 1'b0;
        escreve = 1'b0;
        rejeita = 1'b0;
        novo    = atual;
        case (estado)
            OCIOSO: begin
                if ((pontos != 2'd0) && armado) begin
                    proximo = APLICA;
                    captura = 1'b1;
                end
            end
            APLICA: begin
                proximo = ESPERA;
                if (!sinal_q) begin
                    if (soma <= LIMITE) begin
                        escreve = 1'b1;
                        novo    = soma[LARGURA-1:0];
                    end else begin
                        rejeita = 1'b1;
                    end
                end else begin
                    if (atual >= LARGURA'(valor_q)) begin
                        escreve = 1'b1;
                        novo    = atual - LARGURA'(valor_q);
                    end else begin
                        rejeita = 1'b1;
                    end
                end
            end
            ESPERA: begin
                if (pontos == 2'd0) proximo = OCIOSO;
            end
            default: proximo = OCIOSO;
        endcase
        if (zerar) begin
            proximo = (pontos != 2'd0) ? ESPERA : OCIOSO;
            captura = 1'b0;
            escreve = 1'b0;
            rejeita = 1'b0;
        end
    end

    // A press is only recognised after pontos has been seen at zero, so a button held
    // through reset does not count as a new press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) armado <= 1'b0;
        else       armado <= (pontos == 2'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valor_q <= 2'd0;
            sinal_q <= 1'b0;
            time_q  <= 1'b0;
        end else if (captura) begin
            valor_q <= pontos;
            sinal_q <= chave_neg_pos;
            time_q  <= mudar_time;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            placar_a <= '0;
            placar_b <= '0;
        end else if (zerar) begin
            placar_a <= '0;
            placar_b <= '0;
        end else if (escreve) begin
            if (time_q) placar_b <= novo;
            else        placar_a <= novo;
        end
    end

    // The alarm stays on while the counter is nonzero; a new reject reloads it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 contador <= '0;
        else if (zerar)            contador <= '0;
        else if (rejeita)          contador <= CARGA;
        else if (contador != '0)   contador <= contador - CW'(1);
    end

endmodule

// File: tb/tb_placar_registro_times.sv
// Testbench for placar_registro_times: directed vector table, hand-written corner sequences
// and a randomized run, all checked against a press-level reference model.
module tb_placar_registro_times;
    localparam int LARGURA    = 7;
    localparam int MAX_PONTOS = 99;
    localparam int ALARME     = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         pontos;
    logic               chave_neg_pos;
    logic               mudar_time;
    logic               zerar;
    logic [LARGURA-1:0] placar_a;
    logic [LARGURA-1:0] placar_b;
    logic [LARGURA-1:0] placar_sel;
    logic               alarme;
    logic               ocupado;

    int checks   = 0;
    int failures = 0;
    int alHigh   = 0;

    int mScore[2];
    int mAlarm;
    bit mPend;
    bit mWait;
    bit mArmed;
    int mValor;
    bit mNeg;
    bit mTime;

    logic [1:0] rp;
    logic       rn;
    logic       rt;
    logic       rz;

    typedef struct {
        logic [1:0] p;
        logic       neg;
        logic       tm;
        logic       zr;
        int         expA;
        int         expB;
        int         expSel;
        int         expAl;
        int         expOc;
    } vec_t;

    vec_t tabela[14];

    placar_registro_times #(
        .LARGURA(LARGURA),
        .MAX_PONTOS(MAX_PONTOS),
        .ALARME_CICLOS(ALARME)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pontos(pontos),
        .chave_neg_pos(chave_neg_pos),
        .mudar_time(mudar_time),
        .zerar(zerar),
        .placar_a(placar_a),
        .placar_b(placar_b),
        .placar_sel(placar_sel),
        .alarme(alarme),
        .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mScore[0] = 0;
        mScore[1] = 0;
        mAlarm    = 0;
        mPend     = 1'b0;
        mWait     = 1'b0;
        mArmed    = 1'b0;
        mValor    = 0;
        mNeg      = 1'b0;
        mTime     = 1'b0;
    endtask

    // Behaviour of one clock edge in terms of presses, scores and remaining alarm time.
    task automatic modelStep();
        int p;
        int nextAlarm;
        int r;
        p = int'(pontos);
        if (zerar) begin
            mScore[0] = 0;
            mScore[1] = 0;
            mAlarm    = 0;
            mPend     = 1'b0;
            mWait     = (p != 0);
            mArmed    = (p == 0);
            return;
        end
        nextAlarm = (mAlarm > 0) ? mAlarm - 1 : 0;
        if (mPend) begin
            mPend = 1'b0;
            mWait = 1'b1;
            if (!mNeg) begin
                r = mScore[mTime] + mValor;
                if (r <= MAX_PONTOS) mScore[mTime] = r;
                else                 nextAlarm = ALARME;
            end else begin
                if (mScore[mTime] >= mValor) mScore[mTime] = mScore[mTime] - mValor;
                else                         nextAlarm = ALARME;
            end
        end else if (mWait) begin
            if (p == 0) mWait = 1'b0;
        end else if ((p != 0) && mArmed) begin
            mPend  = 1'b1;
            mValor = p;
            mNeg   = chave_neg_pos;
            mTime  = mudar_time;
        end
        mArmed = (p == 0);
        mAlarm = nextAlarm;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " placar_a"}, int'(placar_a), mScore[0]);
        checkVal({tag, " placar_b"}, int'(placar_b), mScore[1]);
        checkVal({tag, " placar_sel"}, int'(placar_sel), mScore[mudar_time]);
        checkVal({tag, " alarme"}, int'(alarme), (mAlarm > 0) ? 1 : 0);
        checkVal({tag, " ocupado"}, int'(ocupado), (mPend || mWait) ? 1 : 0);
    endtask

    task automatic applyStimulus(input logic [1:0] p, input logic neg, input logic tm,
                                 input logic zr, input string tag);
        pontos        = p;
        chave_neg_pos = neg;
        mudar_time    = tm;
        zerar         = zr;
        @(posedge clk);
        modelStep();
        #1;
        if (alarme) alHigh++;
        checkOutput(tag);
    endtask

    task automatic press(input logic [1:0] v, input logic neg, input logic tm, input string tag);
        applyStimulus(v, neg, tm, 1'b0, tag);
        applyStimulus(2'd0, neg, tm, 1'b0, tag);
        applyStimulus(2'd0, neg, tm, 1'b0, tag);
    endtask

    initial begin
        reset         = 1'b1;
        pontos        = 2'd0;
        chave_neg_pos = 1'b0;
        mudar_time    = 1'b0;
        zerar         = 1'b0;
        modelReset();

        tabela[0]  = '{2'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        tabela[1]  = '{2'd2, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1};
        tabela[2]  = '{2'd2, 1'b0, 1'b0, 1'b0, 2, 0, 2, 0, 1};
        tabela[3]  = '{2'd2, 1'b0, 1'b0, 1'b0, 2, 0, 2, 0, 1};
        tabela[4]  = '{2'd0, 1'b0, 1'b0, 1'b0, 2, 0, 2, 0, 0};
        tabela[5]  = '{2'd3, 1'b0, 1'b1, 1'b0, 2, 0, 0, 0, 1};
        tabela[6]  = '{2'd0, 1'b0, 1'b1, 1'b0, 2, 3, 3, 0, 1};
        tabela[7]  = '{2'd0, 1'b0, 1'b1, 1'b0, 2, 3, 3, 0, 0};
        tabela[8]  = '{2'd3, 1'b0, 1'b1, 1'b0, 2, 3, 3, 0, 1};
        tabela[9]  = '{2'd0, 1'b0, 1'b1, 1'b0, 2, 6, 6, 0, 1};
        tabela[10] = '{2'd0, 1'b0, 1'b1, 1'b0, 2, 6, 6, 0, 0};
        tabela[11] = '{2'd1, 1'b0, 1'b1, 1'b0, 2, 6, 6, 0, 1};
        tabela[12] = '{2'd0, 1'b0, 1'b1, 1'b0, 2, 7, 7, 0, 1};
        tabela[13] = '{2'd0, 1'b0, 1'b1, 1'b0, 2, 7, 7, 0, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("reset");
        checkVal("reset placar_a const", int'(placar_a), 0);
        checkVal("reset alarme const", int'(alarme), 0);

        // Single press held for three cycles, then team B presses 3, 3, 1.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(tabela[i].p, tabela[i].neg, tabela[i].tm, tabela[i].zr, "vec");
            checkVal($sformatf("vec%0d placar_a", i), int'(placar_a), tabela[i].expA);
            checkVal($sformatf("vec%0d placar_b", i), int'(placar_b), tabela[i].expB);
            checkVal($sformatf("vec%0d placar_sel", i), int'(placar_sel), tabela[i].expSel);
            checkVal($sformatf("vec%0d alarme", i), int'(alarme), tabela[i].expAl);
            checkVal($sformatf("vec%0d ocupado", i), int'(ocupado), tabela[i].expOc);
        end

        // Upper bound: 98 + 1 legal, next +1 rejected with an 8-cycle alarm.
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, "zerar3");
        for (int i = 0; i < 32; i++) press(2'd3, 1'b0, 1'b0, "fill");
        press(2'd2, 1'b0, 1'b0, "fill");
        checkVal("t3 A=98", int'(placar_a), 98);
        alHigh = 0;
        press(2'd1, 1'b0, 1'b0, "t3 to99");
        checkVal("t3 A=99", int'(placar_a), 99);
        checkVal("t3 no alarm at 99", alHigh, 0);
        alHigh = 0;
        press(2'd1, 1'b0, 1'b0, "t3 over");
        repeat (10) applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, "t3 idle");
        checkVal("t3 A stays 99", int'(placar_a), 99);
        checkVal("t3 alarm cycles", alHigh, 8);

        // Lower bound and alarm retrigger.
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, "zerar4");
        press(2'd1, 1'b0, 1'b0, "t4 add1");
        press(2'd2, 1'b1, 1'b0, "t4 sub2");
        checkVal("t4 A stays 1", int'(placar_a), 1);
        checkVal("t4 alarm on", int'(alarme), 1);
        repeat (10) applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, "t4 idle");
        alHigh = 0;
        press(2'd1, 1'b1, 1'b0, "t4 sub1");
        checkVal("t4 A=0", int'(placar_a), 0);
        checkVal("t4 no alarm at 0", alHigh, 0);
        alHigh = 0;
        press(2'd1, 1'b1, 1'b0, "t4 rej1");
        press(2'd1, 1'b1, 1'b0, "t4 rej2");
        repeat (12) applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, "t4 idle2");
        checkVal("t4 retrigger cycles", alHigh, 11);

        // Latched team survives a switch flip; zerar in the middle of an alarm.
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, "zerar5");
        applyStimulus(2'd2, 1'b0, 1'b0, 1'b0, "t5 press");
        applyStimulus(2'd0, 1'b0, 1'b1, 1'b0, "t5 flip");
        applyStimulus(2'd0, 1'b0, 1'b1, 1'b0, "t5 flip");
        checkVal("t5 A=2", int'(placar_a), 2);
        checkVal("t5 B=0", int'(placar_b), 0);
        press(2'd3, 1'b0, 1'b1, "t5 B3");
        press(2'd3, 1'b1, 1'b0, "t5 rej");
        checkVal("t5 alarm on", int'(alarme), 1);
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, "t5 zerar");
        checkVal("t5 zerar A", int'(placar_a), 0);
        checkVal("t5 zerar B", int'(placar_b), 0);
        checkVal("t5 zerar alarme", int'(alarme), 0);

        // Reset during APLICA, pontos held across reset release.
        press(2'd2, 1'b0, 1'b0, "t6 A2");
        applyStimulus(2'd1, 1'b0, 1'b0, 1'b0, "t6 aplica");
        checkVal("t6 ocupado before reset", int'(ocupado), 1);
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("t6 in reset");
        checkVal("t6 reset A", int'(placar_a), 0);
        checkVal("t6 reset ocupado", int'(ocupado), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) applyStimulus(2'd1, 1'b0, 1'b0, 1'b0, "t6 held");
        checkVal("t6 held A", int'(placar_a), 0);
        checkVal("t6 held ocupado", int'(ocupado), 0);
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, "t6 release");
        press(2'd1, 1'b0, 1'b0, "t6 repress");
        checkVal("t6 A=1", int'(placar_a), 1);

        // Randomized run: mostly adds first, mostly subtracts later.
        rp = 2'd0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0)
                rp = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            rn = (i < 400) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 4) != 0);
            rt = 1'($urandom_range(0, 1));
            rz = ($urandom_range(0, 150) == 0);
            applyStimulus(rp, rn, rt, rz, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
